// File: rtl/mic_sample_fifo.sv
// rtl/mic_sample_fifo.sv - Mic sample capture FIFO with FWFT read side; optional MIC_BOOST_EN gain stage
module mic_sample_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int BOOST_SHIFT = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [15:0]           in_data,
    input  logic                  in_ready,
    output logic [15:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_rd,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clr_ovf,
    output logic [7:0]            drop_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  in_ready_q;
    logic                  wr_ev;
    logic                  pop;
    logic                  full;
    logic                  wr_ok;
    logic                  drop;
    logic [15:0]           wr_data;

`ifdef MIC_BOOST_EN
    logic signed [31:0] boosted;

    // Shift in a wide signed domain so the saturation test sees the true magnitude.
    always_comb begin
        boosted = 32'(signed'(in_data)) <<< BOOST_SHIFT;
        if (boosted > 32'sd32767)
            wr_data = 16'h7FFF;
        else if (boosted < -32'sd32768)
            wr_data = 16'h8000;
        else
            wr_data = boosted[15:0];
    end
`else
    assign wr_data = in_data;
`endif

    assign wr_ev     = in_ready & ~in_ready_q;
    assign out_valid = (level != '0);
    assign full      = (level == FULL_LEVEL);
    assign pop       = out_rd & out_valid;
    // A pop on a full FIFO frees the slot the same cycle, so the write is not dropped.
    assign wr_ok     = wr_ev & (~full | pop);
    assign drop      = wr_ev & full & ~pop;
    assign out_data  = out_valid ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clock) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
        end else begin
            in_ready_q <= in_ready;
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_ok, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // A drop coinciding with clr_ovf restarts the count at one rather than losing the event.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf)
                drop_count <= 8'd1;
            else if (drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end else if (clr_ovf) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end
    end

endmodule

// File: tb/tb_mic_sample_fifo.sv
// tb/tb_mic_sample_fifo.sv - Directed self-checking bench for mic_sample_fifo
module tb_mic_sample_fifo;

    logic        clock;
    logic        reset_n;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_rd;
    logic [4:0]  level;
    logic        overflow;
    logic        clr_ovf;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    mic_sample_fifo #(.DEPTH_LOG2(4), .BOOST_SHIFT(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_rd     (out_rd),
        .level      (level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .drop_count (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [15:0] d);
        in_data  = d;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        tick();
    endtask

    task automatic pop1();
        out_rd = 1'b1;
        tick();
        out_rd = 1'b0;
    endtask

    task automatic push_check(input logic [15:0] d, input logic [15:0] exp);
        strobe(d);
        chk("boost_data", {16'h0, out_data}, {16'h0, exp});
        pop1();
    endtask

    initial begin
        reset_n  = 1'b0;
        in_data  = 16'h0;
        in_ready = 1'b0;
        out_rd   = 1'b0;
        clr_ovf  = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_data", {16'h0, out_data}, 32'h0);
        chk("rst_level", {27'h0, level}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        chk("rst_drop", {24'h0, drop_count}, 32'h0);
        reset_n = 1'b1;
        tick();

        // single pulse, write-to-valid latency of one clock
        in_data  = 16'h1234;
        in_ready = 1'b1;
        tick();
        chk("t1_valid", {31'h0, out_valid}, 32'h1);
        chk("t1_data", {16'h0, out_data}, 32'h1234);
        chk("t1_level", {27'h0, level}, 32'd1);
        in_ready = 1'b0;
        pop1();
        chk("t1_pop_valid", {31'h0, out_valid}, 32'h0);
        chk("t1_pop_level", {27'h0, level}, 32'd0);

        // out_rd while empty is ignored
        pop1();
        chk("rd_empty_level", {27'h0, level}, 32'd0);

        // held strobe writes once
        in_data  = 16'h0AAA;
        in_ready = 1'b1;
        repeat (5) tick();
        in_ready = 1'b0;
        tick();
        chk("held_level", {27'h0, level}, 32'd1);
        chk("held_data", {16'h0, out_data}, 32'h0AAA);
        pop1();

        // overflow on the 17th sample, order preserved
        for (int i = 1; i <= 17; i++) strobe(16'(i));
        chk("ovf_level", {27'h0, level}, 32'd16);
        chk("ovf_flag", {31'h0, overflow}, 32'h1);
        chk("ovf_drop", {24'h0, drop_count}, 32'd1);
        for (int i = 1; i <= 16; i++) begin
            chk("ovf_order", {16'h0, out_data}, 32'(i));
            pop1();
        end
        chk("ovf_drain", {27'h0, level}, 32'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_flag", {31'h0, overflow}, 32'h0);
        chk("clr_drop", {24'h0, drop_count}, 32'd0);

        // full FIFO, write and pop in the same cycle
        for (int i = 0; i < 16; i++) strobe(16'(16'h0100 + i));
        in_data  = 16'h00FF;
        in_ready = 1'b1;
        out_rd   = 1'b1;
        tick();
        in_ready = 1'b0;
        out_rd   = 1'b0;
        tick();
        chk("full_rw_level", {27'h0, level}, 32'd16);
        chk("full_rw_ovf", {31'h0, overflow}, 32'h0);
        chk("full_rw_head", {16'h0, out_data}, 32'h0101);
        for (int i = 1; i < 16; i++) begin
            chk("full_rw_order", {16'h0, out_data}, 32'(16'h0100 + i));
            pop1();
        end
        chk("full_rw_last", {16'h0, out_data}, 32'h00FF);
        pop1();
        chk("full_rw_drain", {27'h0, level}, 32'd0);

        // drop counter saturation, then drop coinciding with clear
        for (int i = 0; i < 16; i++) strobe(16'(i));
        for (int i = 0; i < 300; i++) strobe(16'hBEEF);
        chk("sat_drop", {24'h0, drop_count}, 32'd255);
        chk("sat_ovf", {31'h0, overflow}, 32'h1);
        chk("sat_level", {27'h0, level}, 32'd16);
        in_ready = 1'b1;
        clr_ovf  = 1'b1;
        tick();
        in_ready = 1'b0;
        clr_ovf  = 1'b0;
        tick();
        chk("clr_drop_ovf", {31'h0, overflow}, 32'h1);
        chk("clr_drop_cnt", {24'h0, drop_count}, 32'd1);
        for (int i = 0; i < 16; i++) pop1();
        chk("sat_drain", {27'h0, level}, 32'd0);

        // write and out_rd on an empty FIFO
        in_data  = 16'h5A5A;
        in_ready = 1'b1;
        out_rd   = 1'b1;
        tick();
        in_ready = 1'b0;
        out_rd   = 1'b0;
        chk("empty_rw_level", {27'h0, level}, 32'd1);
        chk("empty_rw_data", {16'h0, out_data}, 32'h5A5A);
        pop1();

`ifdef MIC_BOOST_EN
        push_check(16'h1000, 16'h4000);
        push_check(16'h2001, 16'h7FFF);
        push_check(16'hC000, 16'h8000);
        push_check(16'hFFFF, 16'hFFFC);
`else
        push_check(16'h2001, 16'h2001);
        push_check(16'hC000, 16'hC000);
`endif

        // reset mid-stream discards contents and a high strobe
        strobe(16'h1111);
        strobe(16'h2222);
        in_ready = 1'b1;
        reset_n  = 1'b0;
        #1;
        chk("mid_rst_level", {27'h0, level}, 32'd0);
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        in_data = 16'h3333;
        tick();
        reset_n = 1'b1;
        tick();
        in_ready = 1'b0;
        chk("post_rst_level", {27'h0, level}, 32'd1);
        chk("post_rst_data", {16'h0, out_data}, 32'h3333);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic_sample_fifo.md
Name: mic_sample_fifo

Overview:
Downstream consumer of the I2S microphone deserializer. Captures each 16-bit mic sample on the rising edge of the deserializer's ready strobe and stores it in a small synchronous FIFO. Presents samples to the packet/transmit logic through a first-word-fall-through valid/read handshake, with level, sticky overflow and dropped-sample count for status reporting. Single clock domain, same clock as the deserializer.

Parameters:
DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries (16 by default); legal range 2..8.
BOOST_SHIFT, 2, left-shift applied to samples when MIC_BOOST_EN is defined; legal range 0..8; ignored otherwise.

Ports:
clock  input  1  system clock; all logic on posedge.
reset_n  input  1  asynchronous, active-low reset.
in_data  input  16  signed two's-complement mic sample from the deserializer.
in_ready  input  1  sample strobe from the deserializer; may be high for one or more cycles.
out_data  output  16  head-of-FIFO sample; valid when out_valid=1.
out_valid  output  1  FIFO not empty.
out_rd  input  1  consumer pop request; honoured only when out_valid=1.
level  output  DEPTH_LOG2+1  number of stored samples, 0..2**DEPTH_LOG2.
overflow  output  1  sticky flag: a sample was dropped because the FIFO was full.
clr_ovf  input  1  clears overflow and drop_count.
drop_count  output  8  dropped-sample count, saturating at 255.

Behaviour:
- Reset (reset_n=0, asynchronous): write/read pointers=0, level=0, out_valid=0, out_data=0, overflow=0, drop_count=0, strobe-edge register=0. No memory clear required.
- Strobe detect: registered copy of in_ready; write event wr_ev = in_ready & ~in_ready_q. A strobe held high for N cycles produces exactly one write.
- Write: on wr_ev and not full, in_data (post-boost, see Optional Feature) is stored at the write pointer; pointer increments modulo depth.
- Full drop: on wr_ev while full and no pop in the same cycle, sample discarded, overflow<=1, drop_count increments, saturating at 255.
- Read: pop = out_rd & out_valid. Pop advances the read pointer modulo depth. out_rd while out_valid=0 is ignored with no state change.
- FWFT: out_data always reflects the entry at the read pointer. A sample written in cycle T is visible with out_valid=1 in cycle T+1 (write-to-valid latency 1 clock).
- Simultaneous write and pop:
  - Not full and not empty: both occur, level unchanged.
  - Full: pop frees the slot, the write is accepted, no drop, level stays at depth.
  - Empty: pop is ignored; the write is accepted and level becomes 1.
- Level: +1 on write only, -1 on pop only, unchanged on both or neither. full = (level==2**DEPTH_LOG2), empty = (level==0).
- Pointers: DEPTH_LOG2 bits each, wrap naturally. Level is kept as a separate counter.
- clr_ovf: synchronous. Clears overflow and drop_count next cycle. If a drop occurs in the same cycle as clr_ovf, the drop wins: overflow=1 and drop_count=1.
- No reset-domain crossing. A reset mid-stream discards all contents and a partially asserted strobe. After reset release, a strobe already high at the first clock counts as a rising edge (in_ready_q=0).

Optional Feature:
MIC_BOOST_EN. When defined, each sample is arithmetically shifted left by BOOST_SHIFT before storage, with signed saturation to 16 bits: result > 32767 becomes 32767; result < -32768 becomes -32768. The shift and saturation are combinational in the write path, so latency is unchanged. When undefined, samples are stored unmodified and BOOST_SHIFT has no effect.

Test Plan:
- Reset, then in_ready pulse 1 cycle with in_data=16'h1234 -> next cycle out_valid=1, out_data=16'h1234, level=1. Then out_rd=1 for 1 cycle -> out_valid=0, level=0.
- in_ready held high 5 cycles with in_data=16'h0AAA -> exactly one entry, level=1.
- 17 strobes (data 1..17), no reads, depth 16 -> level=16, overflow=1, drop_count=1. Reading all 16 returns 1..16 in order. Then clr_ovf -> overflow=0, drop_count=0.
- FIFO full, strobe with data 16'h00FF in the same cycle as out_rd=1 -> no drop, level=16, last entry read is 16'h00FF.
- 300 strobes with the FIFO full and no reads -> drop_count=255 (saturated). clr_ovf asserted in the same cycle as a drop -> overflow=1, drop_count=1.
- MIC_BOOST_EN defined, BOOST_SHIFT=2: input 16'h1000 -> 16'h4000; 16'h2001 -> 16'h7FFF; 16'hC000 -> 16'h8000; 16'hFFFF -> 16'hFFFC. Undefined: 16'h2001 -> 16'h2001.
